// File: rtl/rx_frame_buf_if.sv
// rtl/rx_frame_buf_if.sv - sample input and frame readout signals of rx_frame_buf
interface rx_frame_buf_if #(
    parameter int WIDTH = 24,
    parameter int TS_W  = 32
);
    logic             in_strobe;
    logic [WIDTH-1:0] in_i;
    logic [WIDTH-1:0] in_q;
    logic             frame_rdy;
    logic             rd_bank;
    logic             rd_next;
    logic             rd_done;
    logic [15:0]      rd_dout;
    logic [TS_W-1:0]  frame_ts;
    logic [15:0]      ovfl_cnt;

    modport master (
        output in_strobe, in_i, in_q, rd_next, rd_done,
        input  frame_rdy, rd_bank, rd_dout, frame_ts, ovfl_cnt
    );

    modport slave (
        input  in_strobe, in_i, in_q, rd_next, rd_done,
        output frame_rdy, rd_bank, rd_dout, frame_ts, ovfl_cnt
    );
endinterface

// File: rtl/rx_frame_buf.sv
// rtl/rx_frame_buf.sv - ping-pong I/Q frame buffer with timestamps and 16-bit word readout
module rx_frame_buf #(
    parameter int WIDTH = 24,
    parameter int NSAMP = 170,
    parameter int AW    = 8,
    parameter int TS_W  = 32
) (
    input  logic          adc_clk,
    input  logic          reset_n,
    rx_frame_buf_if.slave bus
);
    localparam int            DW   = 2 * WIDTH;
    localparam logic [AW-1:0] LAST = AW'(NSAMP - 1);

    typedef enum logic {W_FILL, W_WAIT} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SHOW} rd_state_t;

    logic [DW-1:0]   mem_q [0:(2**(AW+1))-1];
    logic [DW-1:0]   rdata_q;
    logic [TS_W-1:0] tick_q;
    logic [TS_W-1:0] ts_q [0:1];
    logic [1:0]      full_q;

    wr_state_t       wr_st_q;
    logic            wr_bank_q;
    logic [AW-1:0]   wr_idx_q;
    logic [15:0]     ovfl_q;

    rd_state_t       rd_st_q;
    logic            rd_bank_q, rd_bank_d;
    logic [AW-1:0]   rd_sidx_q, rd_sidx_d;
    logic [1:0]      rd_widx_q, rd_widx_d;
    logic            frame_rdy_q;
    logic [15:0]     rd_dout_q;

    logic            other_free;
    logic            wr_en;
    logic            wr_bank_eff;
    logic            accept_done;
    logic            accept_next;
    logic            last_word;

    function automatic logic [15:0] pick(input logic [DW-1:0] s, input logic [1:0] w);
        case (w)
            2'd0:    pick = s[DW-1-WIDTH+16 -: 16];
            2'd1:    pick = s[15:0];
            default: pick = {s[DW-1 -: 8], s[WIDTH-1 -: 8]};
        endcase
    endfunction

    // Leaving WAIT_FREE already writes the strobe of that cycle into the freed bank.
    assign other_free  = ~full_q[~wr_bank_q];
    assign wr_en       = bus.in_strobe && (wr_st_q == W_FILL || other_free);
    assign wr_bank_eff = (wr_st_q == W_FILL) ? wr_bank_q : ~wr_bank_q;

    assign last_word   = (rd_sidx_q == LAST) && (rd_widx_q == 2'd2);
    assign accept_done = bus.rd_done && frame_rdy_q;
    assign accept_next = bus.rd_next && !bus.rd_done && (rd_st_q == R_SHOW) && !last_word;

    always_comb begin
        rd_bank_d = rd_bank_q;
        rd_sidx_d = rd_sidx_q;
        rd_widx_d = rd_widx_q;
        if (accept_done) begin
            rd_bank_d = ~rd_bank_q;
            rd_sidx_d = '0;
            rd_widx_d = 2'd0;
        end else if (accept_next) begin
            if (rd_widx_q == 2'd2) begin
                rd_widx_d = 2'd0;
                rd_sidx_d = rd_sidx_q + AW'(1);
            end else begin
                rd_widx_d = rd_widx_q + 2'd1;
            end
        end
    end

    // Read address follows the next-state indices so a new sample is ready one cycle after rd_next.
    always_ff @(posedge adc_clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_eff, wr_idx_q}] <= {bus.in_i, bus.in_q};
        end
        rdata_q <= mem_q[{rd_bank_d, rd_sidx_d}];
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q    <= '0;
            ts_q[0]   <= '0;
            ts_q[1]   <= '0;
            full_q    <= 2'b00;
            wr_st_q   <= W_FILL;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            ovfl_q    <= '0;
        end else begin
            tick_q <= tick_q + TS_W'(1);
            if (accept_done) begin
                full_q[rd_bank_q] <= 1'b0;
            end
            case (wr_st_q)
                W_FILL: begin
                    if (bus.in_strobe) begin
                        if (wr_idx_q == '0) begin
                            ts_q[wr_bank_q] <= tick_q;
                        end
                        if (wr_idx_q == LAST) begin
                            full_q[wr_bank_q] <= 1'b1;
                            wr_idx_q          <= '0;
                            if (!full_q[~wr_bank_q]) begin
                                wr_bank_q <= ~wr_bank_q;
                            end else begin
                                wr_st_q <= W_WAIT;
                            end
                        end else begin
                            wr_idx_q <= wr_idx_q + AW'(1);
                        end
                    end
                end
                default: begin
                    if (other_free) begin
                        wr_bank_q <= ~wr_bank_q;
                        wr_st_q   <= W_FILL;
                        if (bus.in_strobe) begin
                            ts_q[~wr_bank_q] <= tick_q;
                            wr_idx_q         <= AW'(1);
                        end
                    end else if (bus.in_strobe && ovfl_q != 16'hFFFF) begin
                        ovfl_q <= ovfl_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_st_q     <= R_IDLE;
            rd_bank_q   <= 1'b0;
            rd_sidx_q   <= '0;
            rd_widx_q   <= 2'd0;
            frame_rdy_q <= 1'b0;
            rd_dout_q   <= '0;
        end else begin
            rd_bank_q <= rd_bank_d;
            rd_sidx_q <= rd_sidx_d;
            rd_widx_q <= rd_widx_d;
            if (accept_done) begin
                rd_st_q     <= R_IDLE;
                frame_rdy_q <= 1'b0;
            end else begin
                case (rd_st_q)
                    R_IDLE: begin
                        if (full_q[rd_bank_q]) begin
                            rd_st_q <= R_LOAD;
                        end
                    end
                    R_LOAD: begin
                        rd_dout_q   <= pick(rdata_q, rd_widx_q);
                        frame_rdy_q <= 1'b1;
                        rd_st_q     <= R_SHOW;
                    end
                    default: begin
                        if (accept_next) begin
                            rd_st_q <= R_LOAD;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.frame_rdy = frame_rdy_q;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.rd_dout   = rd_dout_q;
    assign bus.frame_ts  = ts_q[rd_bank_q];
    assign bus.ovfl_cnt  = ovfl_q;
endmodule

// File: tb/tb_rx_frame_buf.sv
// tb/tb_rx_frame_buf.sv - scoreboard bench for rx_frame_buf against a frame-level reference model
module tb_rx_frame_buf;
    localparam int N = 4;

    typedef struct packed {
        logic        bank;
        logic [31:0] ts;
        logic [15:0] w0;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cyc = '0;
    int          nvec = 0;
    int          nerr = 0;

    hdr_t        hdr_q[$];
    logic [15:0] wq[$];
    logic [47:0] part_q[$];
    logic [47:0] held_q[$];
    logic [31:0] part_ts = '0;
    int          held = 0;
    int          nframes = 0;
    int          rp = 0;
    int          m_ovfl = 0;

    rx_frame_buf_if #(.WIDTH(24), .TS_W(32)) bus ();

    rx_frame_buf #(.WIDTH(24), .NSAMP(N), .AW(2), .TS_W(32)) dut (
        .adc_clk (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        if (!rst_n) cyc = '0;
        else        cyc = cyc + 32'd1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [47:0] s, input int w);
        logic [23:0] i;
        logic [23:0] q;
        i = s[47:24];
        q = s[23:0];
        if (w == 0)      return i[15:0];
        else if (w == 1) return q[15:0];
        else             return {i[23:16], q[23:16]};
    endfunction

    // Frames complete in order and alternate banks; at most two completed frames may be held.
    task automatic model_strobe(input logic [23:0] i, input logic [23:0] q);
        hdr_t h;
        if (held < 2) begin
            if (part_q.size() == 0) part_ts = cyc;
            part_q.push_back({i, q});
            if (part_q.size() == N) begin
                h.bank = 1'(nframes % 2);
                h.ts   = part_ts;
                h.w0   = word_of(part_q[0], 0);
                hdr_q.push_back(h);
                foreach (part_q[k]) held_q.push_back(part_q[k]);
                part_q.delete();
                held++;
                nframes++;
            end
        end else if (m_ovfl < 65535) begin
            m_ovfl++;
        end
    endtask

    task automatic model_next();
        if (rp < 3 * N - 1) rp++;
        wq.push_back(word_of(held_q[rp / 3], rp % 3));
    endtask

    task automatic model_release();
        held--;
        for (int k = 0; k < N; k++) void'(held_q.pop_front());
        rp = 0;
    endtask

    task automatic model_reset();
        hdr_q.delete();
        wq.delete();
        part_q.delete();
        held_q.delete();
        held = 0;
        nframes = 0;
        rp = 0;
        m_ovfl = 0;
    endtask

    task automatic step(input logic s, input logic [23:0] i, input logic [23:0] q,
                        input logic nx, input logic dn);
        bus.in_strobe = s;
        bus.in_i      = i;
        bus.in_q      = q;
        bus.rd_next   = nx;
        bus.rd_done   = dn;
        if (s) model_strobe(i, q);
        if (bus.frame_rdy) begin
            if (dn)      model_release();
            else if (nx) model_next();
        end
        @(posedge clk);
        #1;
        bus.in_strobe = 1'b0;
        bus.rd_next   = 1'b0;
        bus.rd_done   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_frame(input string nm);
        int k;
        k = 0;
        while (!bus.frame_rdy && k < 20) begin
            idle(1);
            k++;
        end
        check(nm, 32'(bus.frame_rdy), 32'd1);
    endtask

    task automatic read_words(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            idle(2);
        end
    endtask

    task automatic rand_strobes(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: header on every frame_rdy rise, one word two cycles after each accepted rd_next.
    initial begin
        logic       fr_prev;
        logic [1:0] pipe;
        hdr_t       h;
        fr_prev = 1'b0;
        pipe    = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fr_prev = 1'b0;
                pipe    = 2'b00;
            end else begin
                if (pipe[1]) begin
                    if (wq.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL word_unexpected: got 0x%0h expected none", bus.rd_dout);
                    end else begin
                        check("rd_word", 32'(bus.rd_dout), 32'(wq.pop_front()));
                    end
                end
                pipe = {pipe[0], bus.rd_next && !bus.rd_done && bus.frame_rdy};
                if (bus.frame_rdy && !fr_prev) begin
                    if (hdr_q.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL hdr_unexpected: got bank %0d expected none", bus.rd_bank);
                    end else begin
                        h = hdr_q.pop_front();
                        check("hdr_bank", 32'(bus.rd_bank), 32'(h.bank));
                        check("hdr_ts", bus.frame_ts, h.ts);
                        check("hdr_w0", 32'(bus.rd_dout), 32'(h.w0));
                    end
                end
                fr_prev = bus.frame_rdy;
            end
        end
    end

    initial begin
        int cool;
        logic s, nx, dn;
        bus.in_strobe = 1'b0;
        bus.in_i      = '0;
        bus.in_q      = '0;
        bus.rd_next   = 1'b0;
        bus.rd_done   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_frame_rdy", 32'(bus.frame_rdy), 32'd0);
        check("rst_rd_bank", 32'(bus.rd_bank), 32'd0);
        check("rst_rd_dout", 32'(bus.rd_dout), 32'd0);
        check("rst_frame_ts", bus.frame_ts, 32'd0);
        check("rst_ovfl", 32'(bus.ovfl_cnt), 32'd0);

        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(3);
        check("idle_frame_rdy", 32'(bus.frame_rdy), 32'd0);
        check("idle_rd_bank", 32'(bus.rd_bank), 32'd0);
        check("idle_rd_dout", 32'(bus.rd_dout), 32'd0);

        for (int k = 0; k < N; k++)
            step(1'b1, 24'h123456 + 24'(k), 24'hABCDEF - 24'(k), 1'b0, 1'b0);
        wait_frame("f0_ready");
        check("f0_w0_const", 32'(bus.rd_dout), 32'h3456);
        read_words(3 * N + 1);
        check("f0_last_hold", 32'(bus.rd_dout), 32'h12AB);

        rand_strobes(N + 5);
        check("ovfl_5", 32'(bus.ovfl_cnt), 32'd5);
        check("ovfl_model", 32'(bus.ovfl_cnt), 32'(m_ovfl));
        check("bank0_kept", 32'(bus.rd_dout), 32'h12AB);

        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("done_drop_rdy", 32'(bus.frame_rdy), 32'd0);
        check("done_rd_bank", 32'(bus.rd_bank), 32'd1);
        idle(1);
        check("reload_c2", 32'(bus.frame_rdy), 32'd0);
        idle(1);
        check("reload_c3", 32'(bus.frame_rdy), 32'd1);

        rand_strobes(N - 1);
        step(1'b1, 24'($urandom), 24'($urandom), 1'b0, 1'b1);
        rand_strobes(1);
        check("simul_no_drop", 32'(bus.ovfl_cnt), 32'd5);
        wait_frame("f2_ready");
        read_words(4);

        rand_strobes(N - 1);
        rand_strobes(65540);
        check("ovfl_sat", 32'(bus.ovfl_cnt), 32'hFFFF);

        step(1'b0, '0, '0, 1'b0, 1'b1);
        rand_strobes(2);
        wait_frame("f3_ready");
        read_words(1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_frame_rdy", 32'(bus.frame_rdy), 32'd0);
        check("mrst_rd_bank", 32'(bus.rd_bank), 32'd0);
        check("mrst_rd_dout", 32'(bus.rd_dout), 32'd0);
        check("mrst_frame_ts", bus.frame_ts, 32'd0);
        check("mrst_ovfl", 32'(bus.ovfl_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rand_strobes(N);
        wait_frame("fresh_ready");
        check("fresh_bank", 32'(bus.rd_bank), 32'd0);
        read_words(2);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        cool = 0;
        for (int k = 0; k < 800; k++) begin
            s  = ($urandom % 3) != 0;
            nx = 1'b0;
            dn = 1'b0;
            if (cool > 0) begin
                cool--;
            end else if (bus.frame_rdy) begin
                if ($urandom % 5 == 0) dn = 1'b1;
                else                   nx = 1'b1;
                cool = 3;
            end
            step(s, 24'($urandom), 24'($urandom), nx, dn);
        end
        idle(4);
        check("rand_ovfl", 32'(bus.ovfl_cnt), 32'(m_ovfl));
        check("rand_words_drained", 32'(wq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
